// File: rtl/stepper_pos_ctrl_if.sv
// -----------------------------------------------------------------------------
// stepper_pos_ctrl_if
// Command channel between a position source and stepper_pos_ctrl.
//   cmd_valid  : source has a target position to deliver
//   cmd_ready  : controller can take a command this cycle
//   cmd_target : signed absolute target position (two's complement)
// A transfer happens on a clk edge where cmd_valid & cmd_ready are both high.
// -----------------------------------------------------------------------------
interface stepper_pos_ctrl_if #(
  parameter int WIDTH = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_target;

  modport master (
    output cmd_valid,
    output cmd_target,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_pos_ctrl.sv
// -----------------------------------------------------------------------------
// stepper_pos_ctrl
// Closed-loop position controller placed in front of a stepper phase
// generator. Takes a signed absolute target, sets the generator's dir, waits a
// dir-setup time with enable low, then enables motion and counts the fed-back
// step clock until the tracked position equals the target.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   cmd       command channel (slave side): cmd_valid / cmd_ready / cmd_target
//   abort     stop the current move immediately (SETUP or MOVE only)
//   home      zero the position counter (IDLE only; blocks command accept)
//   step_in   step clock from the stepper; one rising edge = one step
//   dir       1 = position increments, 0 = decrements
//   enable    stepper enable, high only in MOVE
//   position  current signed position
//   busy      high in SETUP or MOVE
//   done      one-cycle pulse when a move completes at its target
//   aborted   one-cycle pulse when a move is terminated by abort
// -----------------------------------------------------------------------------
module stepper_pos_ctrl #(
  parameter int WIDTH     = 16,
  parameter int DIR_SETUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  stepper_pos_ctrl_if.slave cmd,
  input  logic             abort,
  input  logic             home,
  input  logic             step_in,
  output logic             dir,
  output logic             enable,
  output logic [WIDTH-1:0] position,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_MOVE  = 2'd2;

  // Wide enough to hold DIR_SETUP-1 and never zero bits wide.
  localparam int CNT_W = (DIR_SETUP < 2) ? 1 : $clog2(DIR_SETUP);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_setup_cnt;
  logic [WIDTH-1:0] r_position;
  logic [WIDTH-1:0] r_target;
  logic             r_dir;
  logic             r_enable;
  logic             r_done;
  logic             r_aborted;
  logic             r_step_q;

  logic             w_step_edge;
  logic             w_cmd_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_pos_step;
  logic             w_hit;

  assign w_step_edge = step_in & ~r_step_q;
  assign w_cmd_ready = (r_state == ST_IDLE) & ~home & ~rst;
  assign w_accept    = cmd.cmd_valid & w_cmd_ready;

  // Position after one step in the current direction; wraps modulo 2^WIDTH.
  assign w_pos_step = r_dir ? (r_position + WIDTH'(1)) : (r_position - WIDTH'(1));
  assign w_hit      = (w_pos_step == r_target);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_setup_cnt <= '0;
      r_position  <= '0;
      r_target    <= '0;
      r_dir       <= 1'b0;
      r_enable    <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_step_q    <= 1'b0;
    end else begin
      r_step_q  <= step_in;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_enable <= 1'b0;
          if (home) begin
            r_position <= '0;
          end else if (w_accept) begin
            if (cmd.cmd_target == r_position) begin
              // Already there: report completion without moving.
              r_done <= 1'b1;
            end else begin
              r_target    <= cmd.cmd_target;
              r_dir       <= ($signed(cmd.cmd_target) > $signed(r_position));
              r_setup_cnt <= SETUP_LOAD;
              r_state     <= ST_SETUP;
            end
          end
        end

        ST_SETUP: begin
          // dir is already stable here; enable stays low for the setup time.
          if (abort) begin
            r_state   <= ST_IDLE;
            r_enable  <= 1'b0;
            r_aborted <= 1'b1;
          end else if (r_setup_cnt == '0) begin
            r_state  <= ST_MOVE;
            r_enable <= 1'b1;
          end else begin
            r_setup_cnt <= r_setup_cnt - CNT_W'(1);
          end
        end

        ST_MOVE: begin
          if (w_step_edge) begin
            r_position <= w_pos_step;
          end
          // A step coincident with abort is counted first; if it lands on the
          // target the move is reported as completed rather than aborted.
          if (w_step_edge && w_hit) begin
            r_state  <= ST_IDLE;
            r_enable <= 1'b0;
            r_done   <= 1'b1;
          end else if (abort) begin
            r_state   <= ST_IDLE;
            r_enable  <= 1'b0;
            r_aborted <= 1'b1;
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_enable <= 1'b0;
        end
      endcase
    end
  end

  assign cmd.cmd_ready = w_cmd_ready;
  assign dir           = r_dir;
  assign enable        = r_enable;
  assign position      = r_position;
  assign busy          = (r_state == ST_SETUP) | (r_state == ST_MOVE);
  assign done          = r_done;
  assign aborted       = r_aborted;

endmodule

// File: doc/stepper_pos_ctrl.md
Name: stepper_pos_ctrl

Overview:
Closed-loop position controller that sits directly upstream of the stepper phase generator. It accepts a signed absolute target over a valid/ready handshake and drives the generator's dir and enable inputs. It counts the generator's step clock (clk_s) as position feedback. It stops the motor exactly when the tracked position reaches the target.

Parameters:
WIDTH, 16, width of position and target (two's complement).
DIR_SETUP, 4, cycles enable is held low after dir is set, before motion starts (minimum 1).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  target command valid
cmd_ready  output  1  controller can accept a command
cmd_target  input  WIDTH  signed absolute target position
abort  input  1  stop the current move immediately
home  input  1  zero the position counter (honoured in IDLE only)
step_in  input  1  step clock fed back from the stepper (clk_s); one rising edge = one step
dir  output  1  to stepper dir; 1 = position increments, 0 = decrements
enable  output  1  to stepper enable
position  output  WIDTH  current signed position
busy  output  1  high in SETUP or MOVE
done  output  1  one-cycle pulse when a move completes at its target
aborted  output  1  one-cycle pulse when a move is terminated by abort

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; position=0, dir=0, enable=0, done=0, aborted=0.
  - Setup counter cleared, step_in edge register cleared.
- Edge detect:
  - step_q <= step_in; step_edge = step_in & ~step_q (one cycle of latency).
  - step_edge is acted on only in MOVE; it is ignored in every other state.
- cmd_ready = (state==IDLE) & ~home & ~rst. A command is accepted when cmd_valid & cmd_ready at a clk edge.
- busy = (state==SETUP) | (state==MOVE). done and aborted are registered pulses, default 0.
- IDLE (enable=0):
  - home=1: position <= 0, no command accepted that cycle.
  - Accept with cmd_target == position: stay IDLE, done=1 on the next cycle.
  - Accept with cmd_target != position: latch target; dir <= (signed cmd_target > signed position); load setup counter with DIR_SETUP-1; go to SETUP.
- SETUP (enable=0, dir stable):
  - Count down; at 0, go to MOVE.
  - enable rises exactly DIR_SETUP cycles after the accept edge.
- MOVE (enable=1):
  - On step_edge: position <= position + 1 if dir=1, else position - 1.
  - If the updated value equals the target: enable <= 0, done <= 1, state <= IDLE, all in the same edge.
  - enable is therefore low starting the cycle after the final counted edge.
- abort=1 in SETUP or MOVE:
  - state <= IDLE, enable <= 0, aborted <= 1, position retained.
  - If step_edge coincides with abort in MOVE, the step is counted first, then the move aborts.
  - If that step also reaches the target, done=1 and aborted=0.
  - abort in IDLE has no effect.
- home outside IDLE is ignored.
- cmd_valid while busy is not accepted; the command must be held until cmd_ready.
- Arithmetic:
  - position wraps modulo 2^WIDTH (0x7FFF+1 -> 0x8000).
  - Direction uses a signed comparison; moves never cross the wrap point by design.
  - Targets are assumed within the signed range.
- Mid-move reset: everything returns to reset values on the next edge; enable=0 immediately after that edge.

Test Plan:
- Reset, then cmd_target=+5 accepted at cycle T:
  - dir=1 at T+1; enable=1 at T+4 (DIR_SETUP=4).
  - Drive 5 step_in pulses -> position=5, enable=0 after the 5th edge, done pulse once, busy=0.
- From position=5, cmd_target=-3 -> dir=0; after 8 steps position=0xFFFD (-3), done pulse.
- step_in pulses while in IDLE and during SETUP -> position unchanged.
- cmd_target equal to the current position (e.g. 5 at 5):
  - cmd_ready high, done on the next cycle.
  - enable never asserts, busy stays 0.
- Move to +10; assert abort after 4 steps:
  - enable=0, aborted=1 for one cycle, position=4.
  - A new command is accepted immediately.
- Abort and step_in edge on the final step (target 3, third edge coincident with abort) -> position=3, done=1, aborted=0.
- home=1 together with cmd_valid in IDLE at position=7:
  - position=0, command not accepted (cmd_ready=0).
  - Command accepted the next cycle after home drops.
- rst=1 mid-MOVE at position=2 -> position=0, enable=0, state IDLE after one edge.
